// File: rtl/bus_interface_unit.sv
// bus_interface_unit
//
// Multiplexed external-bus sequencer. It takes one memory transaction at a
// time from the core and plays it out on a narrow pin bus in this order:
// address beats (MSB first), a control beat, and a data beat. The data beat
// supports wait states and has an optional timeout.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   req, we, addr,    transaction request; captured only while idle
//   wdata
//   ready_o           high only in IDLE
//   ack, err          one-cycle completion pulse; err marks a data-phase timeout
//   rdata             last byte read successfully (registered)
//   pin_addr          address beat to the pins
//   pin_data_out      control/write data to the pins
//   pin_data_in       read data from the pins
//   pin_oe            per-bit output enable, 1 = drive
//   pin_strobe        high during the data beat
//   pin_rdy           external ready; 0 inserts a wait state
//
// Handshake: a transaction is accepted on any rising edge where req=1 and
// ready_o=1. Otherwise req is ignored and is not queued. ack then pulses once
// for the accepted transaction. If reset occurs mid-transaction, the
// transaction is dropped and no ack is produced.
//
// Every output is a register. Each register is loaded with the value that
// decodes from the next state, so the pins change cleanly on clock edges.
// No input has a combinational path to any output.

module bus_interface_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned PIN_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIN_W-1:0]  wdata,
  output logic              ready_o,
  output logic              ack,
  output logic              err,
  output logic [PIN_W-1:0]  rdata,
  output logic [PIN_W-1:0]  pin_addr,
  output logic [PIN_W-1:0]  pin_data_out,
  input  logic [PIN_W-1:0]  pin_data_in,
  output logic [PIN_W-1:0]  pin_oe,
  output logic              pin_strobe,
  input  logic              pin_rdy
);

  localparam int unsigned NBEATS = ADDR_W / PIN_W;
  localparam int unsigned BEAT_W = $clog2(NBEATS + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CTRL = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  // The latched address is shifted left one beat per ADDR cycle. The beat
  // currently on the pins is therefore always the top PIN_W bits.
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  logic                we_q, we_d;
  logic [PIN_W-1:0]    wdata_q, wdata_d;
  logic                tout_q, tout_d;

  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [PIN_W-1:0]    rdata_q, rdata_d;
  logic [PIN_W-1:0]    pin_addr_q, pin_addr_d;
  logic [PIN_W-1:0]    pin_dout_q, pin_dout_d;
  logic [PIN_W-1:0]    pin_oe_q, pin_oe_d;
  logic                strobe_q, strobe_d;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    addr_sh_d = addr_sh_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    tout_d    = tout_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_sh_d = addr;
          we_d      = we;
          wdata_d   = wdata;
          beat_d    = '0;
          wait_d    = '0;
          tout_d    = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          state_d = S_CTRL;
        end else begin
          beat_d    = beat_q + BEAT_W'(1);
          addr_sh_d = addr_sh_q << PIN_W;
        end
      end
      S_CTRL: state_d = S_DATA;
      S_DATA: begin
        if (pin_rdy) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = pin_data_in;
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT))) begin
          // wait_q counts the earlier not-ready cycles, so this is the
          // (TIMEOUT+1)-th consecutive not-ready cycle.
          state_d = S_DONE;
          tout_d  = 1'b1;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Output registers take the decode of the state being entered.
    ready_d    = (state_d == S_IDLE);
    ack_d      = (state_d == S_DONE);
    err_d      = (state_d == S_DONE) && tout_d;
    strobe_d   = (state_d == S_DATA);
    pin_addr_d = (state_d == S_ADDR) ? addr_sh_d[ADDR_W-1 -: PIN_W] : '0;
    pin_oe_d   = '0;
    pin_dout_d = '0;
    if (state_d == S_CTRL) begin
      pin_oe_d      = '1;
      pin_dout_d[0] = ~we_d;
    end else if ((state_d == S_DATA) && we_d) begin
      pin_oe_d   = '1;
      pin_dout_d = wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      wait_q     <= '0;
      addr_sh_q  <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      tout_q     <= 1'b0;
      ready_q    <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      pin_addr_q <= '0;
      pin_dout_q <= '0;
      pin_oe_q   <= '0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      addr_sh_q  <= addr_sh_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      tout_q     <= tout_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      pin_addr_q <= pin_addr_d;
      pin_dout_q <= pin_dout_d;
      pin_oe_q   <= pin_oe_d;
      strobe_q   <= strobe_d;
    end
  end

  assign ready_o      = ready_q;
  assign ack          = ack_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign pin_addr     = pin_addr_q;
  assign pin_data_out = pin_dout_q;
  assign pin_oe       = pin_oe_q;
  assign pin_strobe   = strobe_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Bench for bus_interface_unit.
// Instance 0 uses the default parameters (16-bit address, timeout 15).
// Instance 1 uses a 24-bit address and a timeout of 3.

module tb_bus_interface_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_r[2];
  logic        we_r[2];
  logic [23:0] addr_r[2];
  logic [7:0]  wdata_r[2];
  logic [7:0]  din_r[2];
  logic        rdy_r[2];

  logic        ready_w[2], ack_w[2], err_w[2], strobe_w[2];
  logic [7:0]  rdata_w[2], paddr_w[2], dout_w[2], oe_w[2];

  bus_interface_unit u0 (
    .clk(clk), .rst_n(rst_n), .req(req_r[0]), .we(we_r[0]),
    .addr(addr_r[0][15:0]), .wdata(wdata_r[0]), .ready_o(ready_w[0]),
    .ack(ack_w[0]), .err(err_w[0]), .rdata(rdata_w[0]),
    .pin_addr(paddr_w[0]), .pin_data_out(dout_w[0]),
    .pin_data_in(din_r[0]), .pin_oe(oe_w[0]), .pin_strobe(strobe_w[0]),
    .pin_rdy(rdy_r[0])
  );

  bus_interface_unit #(.ADDR_W(24), .PIN_W(8), .TIMEOUT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_r[1]), .we(we_r[1]),
    .addr(addr_r[1]), .wdata(wdata_r[1]), .ready_o(ready_w[1]),
    .ack(ack_w[1]), .err(err_w[1]), .rdata(rdata_w[1]),
    .pin_addr(paddr_w[1]), .pin_data_out(dout_w[1]),
    .pin_data_in(din_r[1]), .pin_oe(oe_w[1]), .pin_strobe(strobe_w[1]),
    .pin_rdy(rdy_r[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rdata_m[2];
  int ack_cnt[2] = '{0, 0};

  always @(posedge clk) if (ack_w[0]) ack_cnt[0] <= ack_cnt[0] + 1;
  always @(posedge clk) if (ack_w[1]) ack_cnt[1] <= ack_cnt[1] + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {ready, ack, err, strobe, oe, data_out, addr}
  function automatic logic [27:0] obs_pack(input int s);
    return {ready_w[s], ack_w[s], err_w[s], strobe_w[s], oe_w[s], dout_w[s], paddr_w[s]};
  endfunction

  function automatic logic [27:0] mk(input bit rdy, input bit a, input bit e, input bit stb,
                                     input logic [7:0] oe, input logic [7:0] dout,
                                     input logic [7:0] pa);
    return {rdy, a, e, stb, oe, dout, pa};
  endfunction

  // One transaction on instance s with nwait not-ready DATA cycles before
  // pin_rdy goes high. Expected pin behaviour is rebuilt cycle by cycle from
  // the phase the transaction should be in at that cycle.
  task automatic run_txn(input int s, input logic [23:0] a_in, input bit w,
                         input logic [7:0] wd, input int nwait, input logic [7:0] d,
                         input bit busy);
    int nb, tmo, dc, total, base, k;
    bit to;
    logic [23:0] a;
    logic [27:0] exp;
    nb    = (s == 0) ? 2 : 3;
    tmo   = (s == 0) ? 15 : 3;
    a     = (s == 0) ? (a_in & 24'hFFFF) : a_in;
    to    = (tmo != 0) && (nwait > tmo);
    dc    = to ? tmo + 1 : nwait + 1;
    total = nb + dc + 3;
    base  = ack_cnt[s];

    @(negedge clk);
    req_r[s] = 1'b1; we_r[s] = w; addr_r[s] = a; wdata_r[s] = wd;
    rdy_r[s] = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    req_r[s] = 1'b0; we_r[s] = 1'($urandom); addr_r[s] = 24'($urandom);
    wdata_r[s] = 8'($urandom);

    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (i >= nb + 2 && i <= nb + 1 + dc) begin
        rdy_r[s] = ((i - (nb + 2)) >= nwait);
        din_r[s] = rdy_r[s] ? d : 8'($urandom);
      end else begin
        rdy_r[s] = 1'($urandom_range(0, 1));
        din_r[s] = 8'($urandom);
      end
      if (busy && i == 1) req_r[s] = 1'b1;
      if (busy && i == 2) req_r[s] = 1'b0;

      if (i <= nb) begin
        k = i - 1;
        exp = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'((a >> (8 * (nb - 1 - k))) & 24'hFF));
      end else if (i == nb + 1) begin
        exp = mk(0, 0, 0, 0, 8'hFF, {7'b0, ~w}, 8'h00);
      end else if (i <= nb + 1 + dc) begin
        exp = mk(0, 0, 0, 1, w ? 8'hFF : 8'h00, w ? wd : 8'h00, 8'h00);
      end else if (i == nb + 2 + dc) begin
        exp = mk(0, 1, to, 0, 8'h00, 8'h00, 8'h00);
      end else begin
        exp = mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      end
      check($sformatf("s%0d cyc%0d", s, i), 32'(obs_pack(s)), 32'(exp));
    end
    if (!w && !to) rdata_m[s] = d;
    check($sformatf("s%0d rdata", s), 32'(rdata_w[s]), 32'(rdata_m[s]));
    check($sformatf("s%0d ack_count", s), 32'(ack_cnt[s] - base), 32'd1);
  endtask

  task automatic run_b2b();
    int c1, c2, base;
    c1 = -1; c2 = -1; base = ack_cnt[0];
    @(negedge clk);
    req_r[0] = 1'b1; we_r[0] = 1'($urandom); addr_r[0] = 24'($urandom_range(0, 16'hFFFF));
    wdata_r[0] = 8'($urandom); din_r[0] = 8'($urandom); rdy_r[0] = 1'b1;
    for (int c = 0; c < 40 && c2 < 0; c++) begin
      @(negedge clk);
      if (c1 >= 0 && c == c1 + 2) req_r[0] = 1'b0;
      if (ack_w[0]) begin
        if (c1 < 0) c1 = c;
        else c2 = c;
      end
    end
    req_r[0] = 1'b0;
    repeat (8) @(negedge clk);
    if (!we_r[0]) rdata_m[0] = din_r[0];
    check("b2b ack_gap", 32'(c2 - c1), 32'd6);
    check("b2b ack_count", 32'(ack_cnt[0] - base), 32'd2);
    check("b2b rdata", 32'(rdata_w[0]), 32'(rdata_m[0]));
  endtask

  task automatic run_reset_mid_data();
    int base0, base1;
    base0 = ack_cnt[0]; base1 = ack_cnt[1];
    @(negedge clk);
    req_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 24'h00C0DE; wdata_r[0] = 8'h3C;
    rdy_r[0] = 1'b0;
    @(posedge clk);
    #1 req_r[0] = 1'b0;
    repeat (4) @(negedge clk);  // cycle 4 = first DATA cycle
    check("rst pre_oe", 32'(oe_w[0]), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("rst async_oe", 32'(oe_w[0]), 32'h00);
    check("rst async_state", 32'(obs_pack(0)), 32'(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00)));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_r[0] = 1'b1;
    rdata_m[0] = 8'h00; rdata_m[1] = 8'h00;
    repeat (6) @(negedge clk);
    check("rst post_state", 32'(obs_pack(0)), 32'(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00)));
    check("rst no_ack", 32'(ack_cnt[0] - base0), 32'd0);
    check("rst no_ack1", 32'(ack_cnt[1] - base1), 32'd0);
    check("rst rdata0", 32'(rdata_w[0]), 32'(rdata_m[0]));
    check("rst rdata1", 32'(rdata_w[1]), 32'(rdata_m[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_r[s] = 1'b0; we_r[s] = 1'b0; addr_r[s] = '0; wdata_r[s] = '0;
      din_r[s] = '0; rdy_r[s] = 1'b0; rdata_m[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("s%0d reset_state", s), 32'(obs_pack(s)),
            32'(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00)));
      check($sformatf("s%0d reset_rdata", s), 32'(rdata_w[s]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_txn(0, 24'h1234, 1'b1, 8'hA5, 0, 8'h00, 1'b0);
    run_txn(0, 24'hBEEF, 1'b0, 8'h00, 2, 8'h5C, 1'b0);
    run_txn(1, 24'hABCDEF, 1'b0, 8'h00, 0, 8'h77, 1'b0);
    run_txn(1, 24'h123456, 1'b0, 8'h00, 50, 8'h99, 1'b0);
    run_txn(1, 24'h654321, 1'b0, 8'h00, 1, 8'h42, 1'b0);
    run_txn(0, 24'h4321, 1'b0, 8'h00, 20, 8'hEE, 1'b0);
    run_txn(0, 24'h0F0F, 1'b1, 8'h5A, 1, 8'h00, 1'b1);
    run_b2b();

    // Randomised traffic, including timeouts on both instances.
    for (int t = 0; t < 40; t++) begin
      int s, r, nw;
      s  = $urandom_range(0, 1);
      r  = $urandom_range(0, 9);
      nw = (r < 7) ? r : ((s == 1) ? $urandom_range(3, 6) : $urandom_range(14, 17));
      run_txn(s, 24'($urandom), 1'($urandom), 8'($urandom), nw, 8'($urandom),
              $urandom_range(0, 3) == 0);
    end

    run_reset_mid_data();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
